operand_collector: RTL and testbench
====================================

# operand_collector

Parametrised operand collector: gathers up to DEPTH values of WIDTH bits from a valid/ready input stream into ordered slots, then publishes the frame as one parallel word with a per-slot valid mask. A frame publishes when all slots fill or when `commit` closes it early. A separate output stage lets the next frame collect while the previous one waits on `out_ready`. It sits between the instruction-decode stream and the execute stage, supplying grouped operands.

## Interface
- `WIDTH`, 8: bits per value.
- `DEPTH`, 3: slots per frame; legal range 1..16.
- `AUTO_COMMIT`, 1: 1 = publish automatically when the slot count reaches DEPTH; 0 = publish only on `commit`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_value` is offered.
- `in_ready` out 1: collector can accept.
- `in_value` in WIDTH: value to store.
- `commit` in 1: close the current frame.
- `out_valid` out 1: published frame held on outputs.
- `out_ready` in 1: consumer takes the frame.
- `out_data` out DEPTH*WIDTH: slot i at bits [i*WIDTH +: WIDTH]; unfilled slots are 0.
- `out_mask` out DEPTH: bit i = slot i filled.
- `out_count` out $clog2(DEPTH+1): number of filled slots.
- `done` out 1: one-cycle pulse on the edge after a publish.
- `out_sum` out WIDTH+$clog2(DEPTH+1): present only with `OPERAND_COLLECTOR_SUM_EN`.

## Operation
- Collect stage:
  - Registers: `slot[DEPTH]`, `count`, FSM state in {COLLECT, WAIT}.
  - Accept occurs when `in_valid && in_ready`: `slot[count] <= in_value`, `count++`.
  - `in_ready = (state==COLLECT) && (count<DEPTH)`. This is combinational from registers only, with no path from `in_valid`.
- Commit request is true when any of the following holds:
  - `commit && (count_next>0)`;
  - `AUTO_COMMIT && count_next==DEPTH`.
  - Here `count_next` includes a same-cycle accept. `commit` with an empty frame is ignored.
- Output free = `!out_valid || out_ready`.
- Commit request with output free:
  - Load the output stage from the collect stage, including any same-cycle accept.
  - Clear slots and `count` to 0; state becomes COLLECT.
- Commit request with output busy:
  - State becomes WAIT and the frame is frozen; `in_ready=0`.
  - A `commit` arriving in WAIT is redundant and ignored.
- WAIT → COLLECT on the first cycle the output is free; the publish happens on that edge.
- Output stage: `out_valid` clears on `out_valid && out_ready` unless a new publish occurs on the same edge. A same-edge publish replaces the frame back-to-back with no bubble.
- `done` is set exactly on edges that publish, otherwise 0.
- `AUTO_COMMIT=0` with a full frame: `in_ready=0` until `commit`.

## Timing
- Reset, asynchronous and active-low, forces:
  - `out_valid=0`, `out_data=0`, `out_mask=0`, `out_count=0`, `done=0`, `out_sum=0`;
  - slots 0, `count` 0, state COLLECT.
- `in_ready` reads 1 out of reset.
- Latency: a value accepted on edge t, with commit resolved on t, appears on the outputs after edge t.
- Input throughput is one value per cycle. Output throughput is one frame per cycle when `out_ready` is held high.
- Reset asserted mid-frame discards partial and published frames; no `done` is produced.
- `out_data`, `out_mask` and `out_count` hold stable while `out_valid && !out_ready`.

## Configuration
- `OPERAND_COLLECTOR_SUM_EN` defined:
  - Adds port `out_sum`, the zero-extended sum of filled slots, registered with the frame.
  - Unsigned, no overflow possible at the stated width.
- Undefined: the port and the adder are absent; all other behaviour is identical.

## Structure
- Package `operand_collector_pkg`:
  - state enum `oc_state_e` {COLLECT, WAIT};
  - function `oc_cnt_w(depth)` returning $clog2(depth+1).
- One sub-module, `oc_out_stage`: the output register with valid/ready hold, `done` generation, and optional sum register.
- The collect stage and FSM stay in the top module.

## Test plan
- DEPTH=3, AUTO_COMMIT=1, `out_ready=1`; inputs 0x11, 0x22, 0x33 on consecutive cycles → after the third edge: `out_data=0x332211`, `out_mask=3'b111`, `out_count=3`, `done` pulses once; `out_sum=0x066` if enabled.
- Input 0xA5, then `commit` next cycle with no input → `out_data=0x0000A5`, `out_mask=3'b001`, `out_count=1`.
- Accept 0x7F with `commit` on the same cycle, `count` previously 1 holding 0x01 → `out_mask=3'b011`, `out_data=0x007F01`.
- `out_ready=0` with a frame held; fill a second frame → state WAIT, `in_ready=0`, outputs unchanged. Raise `out_ready` → second frame replaces the first on that edge and `done` pulses.
- `commit` with `count=0` → no publish and `done` stays 0. Separately, AUTO_COMMIT=0 full frame → `in_ready=0` until `commit`.
- Assert `reset` mid-frame after 2 accepts → all outputs 0 immediately. After release, 3 fresh inputs publish correctly.

Source files
------------

// File: rtl/operand_collector_pkg.sv
// operand_collector_pkg
//   Shared types and helpers for the operand collector.
//   oc_state_e : collect-stage FSM state (COLLECT accepts values, WAIT holds a
//                closed frame until the output stage frees up).
//   oc_cnt_w   : width of a slot counter able to hold 0..depth.
package operand_collector_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        WAIT    = 1'b1
    } oc_state_e;

    function automatic int unsigned oc_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/oc_out_stage.sv
// oc_out_stage
//   Output register of the operand collector. Loads a frame on publish, holds it
//   while out_valid && !out_ready, and drops out_valid once the consumer takes it
//   (unless a new frame publishes on the same edge).
//   Optional: OPERAND_COLLECTOR_SUM_EN adds out_sum, the zero-extended sum of
//   the published slots, registered with the frame.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   publish               load pub_* into the output register this edge
//   pub_data/mask/count   frame being published
//   out_ready             consumer accepts the held frame
//   out_valid/data/mask/count  held frame
//   done                  high for the cycle following a publish edge
//   out_sum               (optional) sum of filled slots
module oc_out_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CW    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     publish,
    input  logic [DEPTH*WIDTH-1:0]   pub_data,
    input  logic [DEPTH-1:0]         pub_mask,
    input  logic [CW-1:0]            pub_count,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DEPTH*WIDTH-1:0]   out_data,
    output logic [DEPTH-1:0]         out_mask,
    output logic [CW-1:0]            out_count,
`ifdef OPERAND_COLLECTOR_SUM_EN
    output logic [WIDTH+CW-1:0]      out_sum,
`endif
    output logic                     done
);

    logic                   valid_d, valid_q;
    logic [DEPTH*WIDTH-1:0] data_d, data_q;
    logic [DEPTH-1:0]       mask_d, mask_q;
    logic [CW-1:0]          count_d, count_q;
    logic                   done_d, done_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mask_d  = mask_q;
        count_d = count_q;
        done_d  = publish;
        if (publish) begin
            valid_d = 1'b1;
            data_d  = pub_data;
            mask_d  = pub_mask;
            count_d = pub_count;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mask  = mask_q;
    assign out_count = count_q;
    assign done      = done_q;

`ifdef OPERAND_COLLECTOR_SUM_EN
    localparam int unsigned SW = WIDTH + CW;
    logic [SW-1:0] sum_d, sum_q;

    // Unfilled slots are zero, so summing every slot equals summing filled ones.
    always_comb begin
        sum_d = sum_q;
        if (publish) begin
            sum_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                sum_d = sum_d + SW'(pub_data[i*WIDTH +: WIDTH]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign out_sum = sum_q;
`endif

endmodule

// File: rtl/operand_collector.sv
// operand_collector
//   Gathers up to DEPTH values of WIDTH bits from a valid/ready stream into
//   ordered slots and publishes them as one parallel word with a valid mask.
//   A frame closes when all slots fill (AUTO_COMMIT=1) or on commit. If the
//   output stage is still busy the closed frame is frozen in WAIT until it frees.
//   Optional: OPERAND_COLLECTOR_SUM_EN adds out_sum (sum of filled slots).
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_value  input stream
//   commit                      close the current (non-empty) frame
//   out_valid/out_ready         output handshake
//   out_data                    slot i at [i*WIDTH +: WIDTH], unfilled = 0
//   out_mask, out_count         filled-slot mask and count
//   done                        one-cycle pulse after each publish edge
//   out_sum                     (optional) zero-extended slot sum
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned AUTO_COMMIT = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_value,
    input  logic                              commit,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DEPTH*WIDTH-1:0]            out_data,
    output logic [DEPTH-1:0]                  out_mask,
    output logic [oc_cnt_w(DEPTH)-1:0]        out_count,
`ifdef OPERAND_COLLECTOR_SUM_EN
    output logic [WIDTH+oc_cnt_w(DEPTH)-1:0]  out_sum,
`endif
    output logic                              done
);

    localparam int unsigned CW = oc_cnt_w(DEPTH);

    oc_state_e                        state_d, state_q;
    logic [DEPTH-1:0][WIDTH-1:0]      slots_d, slots_q;
    logic [CW-1:0]                    count_d, count_q;

    logic                             accept;
    logic [CW-1:0]                    count_next;
    logic [DEPTH-1:0][WIDTH-1:0]      slots_next;
    logic                             commit_req;
    logic                             out_free;
    logic                             publish;
    logic [DEPTH-1:0]                 pub_mask;

    // Depends on registers only; no combinational path from in_valid.
    assign in_ready = (state_q == COLLECT) && (count_q < CW'(DEPTH));
    assign out_free = !out_valid || out_ready;

    always_comb begin
        accept     = in_valid && in_ready;
        count_next = count_q + CW'(accept);
        slots_next = slots_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (accept && (32'(count_q) == i)) begin
                slots_next[i] = in_value;
            end
        end

        // In WAIT the frame is already closed; later commits are redundant.
        commit_req = (state_q == COLLECT) &&
                     ((commit && (count_next != '0)) ||
                      ((AUTO_COMMIT != 0) && (count_next == CW'(DEPTH))));

        publish = ((state_q == COLLECT) && commit_req && out_free) ||
                  ((state_q == WAIT) && out_free);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            pub_mask[i] = (32'(count_next) > i);
        end

        state_d = state_q;
        slots_d = slots_q;
        count_d = count_q;
        if (publish) begin
            state_d = COLLECT;
            slots_d = '0;
            count_d = '0;
        end else if (state_q == COLLECT) begin
            slots_d = slots_next;
            count_d = count_next;
            if (commit_req) begin
                state_d = WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            slots_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            slots_q <= slots_d;
            count_q <= count_d;
        end
    end

    oc_out_stage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .publish   (publish),
        .pub_data  (slots_next),
        .pub_mask  (pub_mask),
        .pub_count (count_next),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_count (out_count),
`ifdef OPERAND_COLLECTOR_SUM_EN
        .out_sum   (out_sum),
`endif
        .done      (done)
    );

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: DEPTH=3 with AUTO_COMMIT=1 (dut) and
// AUTO_COMMIT=0 (dut2) sharing clock, reset and out_ready.
module tb_operand_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_ready;

    logic        in_valid, commit, in_ready, out_valid, done;
    logic [7:0]  in_value;
    logic [23:0] out_data;
    logic [2:0]  out_mask;
    logic [1:0]  out_count;

    logic        in2_valid, commit2, in2_ready, out2_valid, done2;
    logic [7:0]  in2_value;
    logic [23:0] out2_data;
    logic [2:0]  out2_mask;
    logic [1:0]  out2_count;

`ifdef OPERAND_COLLECTOR_SUM_EN
    logic [9:0]  out_sum, out2_sum;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_collector #(.WIDTH(8), .DEPTH(3), .AUTO_COMMIT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .commit    (commit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_count (out_count),
`ifdef OPERAND_COLLECTOR_SUM_EN
        .out_sum   (out_sum),
`endif
        .done      (done)
    );

    operand_collector #(.WIDTH(8), .DEPTH(3), .AUTO_COMMIT(0)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in2_valid),
        .in_ready  (in2_ready),
        .in_value  (in2_value),
        .commit    (commit2),
        .out_valid (out2_valid),
        .out_ready (out_ready),
        .out_data  (out2_data),
        .out_mask  (out2_mask),
        .out_count (out2_count),
`ifdef OPERAND_COLLECTOR_SUM_EN
        .out_sum   (out2_sum),
`endif
        .done      (done2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0; in_value  = 8'h00; commit  = 1'b0;
        in2_valid = 1'b0; in2_value = 8'h00; commit2 = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_out_mask",  64'(out_mask),  64'h0);
        chk("rst_out_count", 64'(out_count), 64'h0);
        chk("rst_done",      64'(done),      64'h0);
        chk("rst_in_ready",  64'(in_ready),  64'h1);
`ifdef OPERAND_COLLECTOR_SUM_EN
        chk("rst_out_sum",   64'(out_sum),   64'h0);
`endif
        reset = 1'b1;
        tick();

        // Full frame via auto-commit.
        in_valid = 1'b1; in_value = 8'h11; tick();
        chk("t1_no_early_valid", 64'(out_valid), 64'h0);
        in_value = 8'h22; tick();
        chk("t1_no_early_done", 64'(done), 64'h0);
        in_value = 8'h33; tick();
        in_valid = 1'b0;
        chk("t1_valid", 64'(out_valid), 64'h1);
        chk("t1_data",  64'(out_data),  64'h332211);
        chk("t1_mask",  64'(out_mask),  64'h7);
        chk("t1_count", 64'(out_count), 64'h3);
        chk("t1_done",  64'(done),      64'h1);
`ifdef OPERAND_COLLECTOR_SUM_EN
        chk("t1_sum",   64'(out_sum),   64'h066);
`endif
        tick();
        chk("t1_drain_valid", 64'(out_valid), 64'h0);
        chk("t1_done_once",   64'(done),      64'h0);

        // Single value then a separate commit.
        in_valid = 1'b1; in_value = 8'hA5; tick();
        in_valid = 1'b0; commit = 1'b1; tick();
        commit = 1'b0;
        chk("t2_data",  64'(out_data),  64'h0000A5);
        chk("t2_mask",  64'(out_mask),  64'h1);
        chk("t2_count", 64'(out_count), 64'h1);
        chk("t2_done",  64'(done),      64'h1);
        tick();

        // Accept together with commit.
        in_valid = 1'b1; in_value = 8'h01; tick();
        in_value = 8'h7F; commit = 1'b1; tick();
        in_valid = 1'b0; commit = 1'b0;
        chk("t3_mask",  64'(out_mask),  64'h3);
        chk("t3_data",  64'(out_data),  64'h007F01);
        chk("t3_count", 64'(out_count), 64'h2);
`ifdef OPERAND_COLLECTOR_SUM_EN
        chk("t3_sum",   64'(out_sum),   64'h080);
`endif
        tick();

        // Backpressure: second frame waits, then replaces the first.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_value = 8'h01; tick();
        in_value = 8'h02; tick();
        in_value = 8'h03; tick();
        chk("t4_first_data", 64'(out_data), 64'h030201);
        in_value = 8'h04; tick();
        in_value = 8'h05; tick();
        in_value = 8'h06; tick();
        chk("t4_wait_in_ready", 64'(in_ready),  64'h0);
        chk("t4_hold_data",     64'(out_data),  64'h030201);
        chk("t4_hold_valid",    64'(out_valid), 64'h1);
        chk("t4_wait_no_done",  64'(done),      64'h0);
        in_value = 8'h99; tick();
        chk("t4_hold_data2",    64'(out_data),  64'h030201);
        chk("t4_hold_count",    64'(out_count), 64'h3);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("t4_second_data",  64'(out_data),  64'h060504);
        chk("t4_second_done",  64'(done),      64'h1);
        chk("t4_second_valid", 64'(out_valid), 64'h1);
        chk("t4_in_ready_back",64'(in_ready),  64'h1);
        tick();
        chk("t4_drain_valid",  64'(out_valid), 64'h0);

        // Commit on an empty frame is ignored.
        commit = 1'b1; tick();
        commit = 1'b0;
        chk("t5_empty_valid", 64'(out_valid), 64'h0);
        chk("t5_empty_done",  64'(done),      64'h0);

        // Reset mid-frame with a published frame held.
        out_ready = 1'b0;
        in_valid = 1'b1; in_value = 8'hAA; commit = 1'b1; tick();
        commit = 1'b0;
        chk("t6_held_valid", 64'(out_valid), 64'h1);
        in_value = 8'h10; tick();
        in_value = 8'h20; tick();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'h0);
        chk("t6_rst_data",  64'(out_data),  64'h0);
        chk("t6_rst_mask",  64'(out_mask),  64'h0);
        chk("t6_rst_count", 64'(out_count), 64'h0);
        chk("t6_rst_done",  64'(done),      64'h0);
        tick();
        chk("t6_rst_no_done", 64'(done), 64'h0);
        reset = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        in_value = 8'h44; tick();
        in_value = 8'h55; tick();
        in_value = 8'h66; tick();
        in_valid = 1'b0;
        chk("t6_fresh_data",  64'(out_data),  64'h665544);
        chk("t6_fresh_mask",  64'(out_mask),  64'h7);
        chk("t6_fresh_count", 64'(out_count), 64'h3);
        chk("t6_fresh_done",  64'(done),      64'h1);
`ifdef OPERAND_COLLECTOR_SUM_EN
        chk("t6_fresh_sum",   64'(out_sum),   64'h0FF);
`endif
        tick();

        // AUTO_COMMIT=0: a full frame stalls input until commit.
        in2_valid = 1'b1;
        in2_value = 8'h01; tick();
        in2_value = 8'h02; tick();
        in2_value = 8'h03; tick();
        chk("t7_no_auto_valid", 64'(out2_valid), 64'h0);
        chk("t7_full_in_ready", 64'(in2_ready),  64'h0);
        in2_value = 8'h77; tick();
        chk("t7_still_stalled", 64'(in2_ready),  64'h0);
        chk("t7_still_no_pub",  64'(done2),      64'h0);
        in2_valid = 1'b0; commit2 = 1'b1; tick();
        commit2 = 1'b0;
        chk("t7_commit_valid", 64'(out2_valid), 64'h1);
        chk("t7_commit_data",  64'(out2_data),  64'h030201);
        chk("t7_commit_mask",  64'(out2_mask),  64'h7);
        chk("t7_commit_done",  64'(done2),      64'h1);
        chk("t7_ready_again",  64'(in2_ready),  64'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
